uart_tx_gen: RTL and testbench
==============================

Name: uart_tx_gen

Overview:
- Parametrised next-generation serial transmitter for the tile top level.
- Frames a parallel word as UART: start bit, DATA_BITS LSB-first, optional parity, 1 or 2 stop bits.
- Two frame sources:
  - a valid/ready handshake, for on-chip producers;
  - a raw push-button input with an internal synchroniser and debouncer, for board bring-up with switch data.
- Baud divisor, word width, parity mode and stop-bit count are all configurable.

Parameters:
DIV, 16, clock cycles per serial bit (legal 2..65535)
DATA_BITS, 8, payload bits per frame (legal 5..9)
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits per frame (1 or 2)
DB_CYCLES, 4, consecutive stable synchronised samples required to change the debounced button level (legal >= 1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  block enable; gates acceptance of new frames only
data_in  in  DATA_BITS  payload word, sampled on accept
valid  in  1  producer request
ready  out  1  = ena && state==IDLE; a frame is accepted on any cycle where ready=1 and (valid=1 or btn_trig=1)
btn_raw  in  1  asynchronous push-button, active high
tx  out  1  serial line, idle high
busy  out  1  high from the cycle after accept until frame end
frame_done  out  1  one-cycle pulse on the final cycle of the last stop bit
btn_db  out  1  debounced button level (debug)

Behaviour:
- Reset (async assert, sync release):
  - tx=1, busy=0, frame_done=0, btn_db=0, state=IDLE, all counters 0, sync flops 0.
  - Asserting reset mid-frame returns tx to 1 immediately; the frame is abandoned.
- Button path:
  - 2-flop synchroniser on btn_raw.
  - Counter increments while the synchronised value differs from btn_db and clears when they match.
  - When the counter reaches DB_CYCLES, btn_db takes the synchronised value and the counter clears.
  - btn_trig = 1-cycle pulse on the btn_db 0->1 edge.
  - A btn_trig arriving while ready=0 is dropped, never queued.
- Accept:
  - On the accept cycle, data_in is latched into the shift register and the parity bit is computed from the latched word.
  - valid and btn_trig in the same cycle produce exactly one frame.
- FSM: IDLE -> START -> DATA -> (PARITY if PARITY!=0) -> STOP -> IDLE.
  - Every bit holds for exactly DIV cycles, counted by the baud counter (0..DIV-1), which reloads at each bit boundary.
  - START: tx=0, beginning the cycle after accept.
  - DATA: DATA_BITS bits, bit 0 first.
  - PARITY: even mode sends ^word; odd mode sends ~^word.
  - STOP: tx=1 for STOP_BITS*DIV cycles.
- Timing:
  - Frame length = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * DIV cycles, measured from the first START cycle.
  - frame_done=1 on the last STOP cycle only.
  - ready=1 on the following cycle (if ena=1).
- Back-to-back: if valid is held high, the next accept occurs in the first IDLE cycle, and START begins one cycle after that. The inter-frame gap is therefore exactly 1 cycle of tx=1 beyond the stop bits.
- ena:
  - Dropping ena mid-frame does not abort the frame.
  - With ena=0, ready=0 and no frames are accepted; the debouncer keeps running.
- data_in and valid changing during a frame have no effect on tx.
- Illegal parameter values are unspecified; the bench uses only legal values.

Test Plan:
- DIV=4, DATA_BITS=8, PARITY=0, STOP_BITS=1; pulse valid with data_in=8'hA5:
  - tx sequence per 4 cycles is 0,1,0,1,0,0,1,0,1,1;
  - busy high for 40 cycles;
  - frame_done pulses once at cycle 40 after accept.
- PARITY=1 then 2, data 8'h07 (three ones):
  - even mode sends parity bit 1; odd mode sends 0;
  - frame is 44 cycles at DIV=4.
- DATA_BITS=5, STOP_BITS=2, DIV=3, valid held high with data 5'h1F:
  - two consecutive frames of 24 cycles each;
  - exactly one idle-high cycle between the second stop bit and the next start bit.
- Button bounce, DB_CYCLES=4:
  - btn_raw toggling every 2 cycles for 20 cycles, then held high: exactly one frame;
  - btn_db rises 2+4 cycles after the stable level;
  - a second press during busy is dropped.
- rst_n asserted during DATA bit 3: tx=1, busy=0 immediately; after release, a new valid produces a clean full frame.
- ena=0 with valid=1: ready=0 and tx stays 1; raising ena starts the frame on the next cycle.

Source files
------------

// File: rtl/uart_tx_gen.sv
// UART frame transmitter with a valid/ready source and a debounced push-button source.
// Frame: start, DATA_BITS LSB-first, optional parity, STOP_BITS stop bits, each DIV cycles long.
module uart_tx_gen #(
    parameter int unsigned DIV       = 16,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1,
    parameter int unsigned DB_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 valid,
    output logic                 ready,
    input  logic                 btn_raw,
    output logic                 tx,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 btn_db
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned IDX_W = 4;
    localparam int unsigned DB_W  = $clog2(DB_CYCLES + 1);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DB_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // Button path: 2-flop synchroniser, stability counter, rising-edge detect
    logic            sync1;
    logic            sync2;
    logic            btn_prev;
    logic [DB_W-1:0] db_cnt;
    logic            btn_trig;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            btn_prev <= 1'b0;
            btn_db   <= 1'b0;
            db_cnt   <= '0;
        end else begin
            sync1    <= btn_raw;
            sync2    <= sync1;
            btn_prev <= btn_db;
            if (sync2 == btn_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                btn_db <= sync2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    assign btn_trig = btn_db & ~btn_prev;

    // Frame sequencer state
    state_t                 state;
    state_t                 state_n;
    logic [CNT_W-1:0]       baud_cnt;
    logic [CNT_W-1:0]       baud_cnt_n;
    logic [IDX_W-1:0]       bit_idx;
    logic [IDX_W-1:0]       bit_idx_n;
    logic [DATA_BITS-1:0]   shreg;
    logic [DATA_BITS-1:0]   shreg_n;
    logic                   par_bit;
    logic                   par_bit_n;
    logic                   tx_n;
    logic                   busy_n;
    logic                   frame_done_n;
    logic                   accept;
    logic                   bit_end;

    assign ready   = ena && (state == S_IDLE);
    assign accept  = ready && (valid || btn_trig);
    assign bit_end = (baud_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            baud_cnt   <= baud_cnt_n;
            bit_idx    <= bit_idx_n;
            shreg      <= shreg_n;
            par_bit    <= par_bit_n;
            tx         <= tx_n;
            busy       <= busy_n;
            frame_done <= frame_done_n;
        end
    end

    // Next state, then registered outputs derived from the next state so they align with it
    always_comb begin
        state_n      = state;
        baud_cnt_n   = baud_cnt;
        bit_idx_n    = bit_idx;
        shreg_n      = shreg;
        par_bit_n    = par_bit;
        tx_n         = 1'b1;
        busy_n       = 1'b0;
        frame_done_n = 1'b0;

        if (state == S_IDLE) begin
            baud_cnt_n = '0;
            bit_idx_n  = '0;
            if (accept) begin
                state_n   = S_START;
                shreg_n   = data_in;
                par_bit_n = (PARITY == 2) ? ~(^data_in) : (^data_in);
            end
        end else if (!bit_end) begin
            baud_cnt_n = baud_cnt + CNT_W'(1);
        end else begin
            baud_cnt_n = '0;
            case (state)
                S_START: begin
                    state_n   = S_DATA;
                    bit_idx_n = '0;
                end
                S_DATA: begin
                    if (bit_idx == DATA_LAST) begin
                        bit_idx_n = '0;
                        state_n   = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_idx_n = bit_idx + IDX_W'(1);
                        shreg_n   = shreg >> 1;
                    end
                end
                S_PARITY: begin
                    state_n   = S_STOP;
                    bit_idx_n = '0;
                end
                S_STOP: begin
                    if (bit_idx == STOP_LAST) begin
                        state_n   = S_IDLE;
                        bit_idx_n = '0;
                    end else begin
                        bit_idx_n = bit_idx + IDX_W'(1);
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end

        case (state_n)
            S_START:  tx_n = 1'b0;
            S_DATA:   tx_n = shreg_n[0];
            S_PARITY: tx_n = par_bit_n;
            default:  tx_n = 1'b1;
        endcase
        busy_n       = (state_n != S_IDLE);
        frame_done_n = (state_n == S_STOP) && (baud_cnt_n == CNT_LAST) &&
                       (bit_idx_n == STOP_LAST);
    end

endmodule

// File: tb/tb_uart_tx_gen.sv
// Self-checking bench for uart_tx_gen: four parameter sets, vector table, corner sequences,
// and random frames checked against a frame-bit model.
module tb_uart_tx_gen;

    logic       clk;
    logic       rst_n;
    logic       ena_r   [4];
    logic       valid_r [4];
    logic       btn_r   [4];
    logic [8:0] data_r  [4];
    logic       ready_w [4];
    logic       tx_w    [4];
    logic       busy_w  [4];
    logic       done_w  [4];
    logic       db_w    [4];

    int errors = 0;
    int checks = 0;
    int done_cnt [4] = '{0, 0, 0, 0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_tx_gen #(.DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DB_CYCLES(4)) u0 (
        .clk(clk), .rst_n(rst_n), .ena(ena_r[0]), .data_in(data_r[0][7:0]), .valid(valid_r[0]),
        .ready(ready_w[0]), .btn_raw(btn_r[0]), .tx(tx_w[0]), .busy(busy_w[0]),
        .frame_done(done_w[0]), .btn_db(db_w[0]));
    uart_tx_gen #(.DIV(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .DB_CYCLES(4)) u1 (
        .clk(clk), .rst_n(rst_n), .ena(ena_r[1]), .data_in(data_r[1][7:0]), .valid(valid_r[1]),
        .ready(ready_w[1]), .btn_raw(btn_r[1]), .tx(tx_w[1]), .busy(busy_w[1]),
        .frame_done(done_w[1]), .btn_db(db_w[1]));
    uart_tx_gen #(.DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .DB_CYCLES(4)) u2 (
        .clk(clk), .rst_n(rst_n), .ena(ena_r[2]), .data_in(data_r[2][7:0]), .valid(valid_r[2]),
        .ready(ready_w[2]), .btn_raw(btn_r[2]), .tx(tx_w[2]), .busy(busy_w[2]),
        .frame_done(done_w[2]), .btn_db(db_w[2]));
    uart_tx_gen #(.DIV(3), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2), .DB_CYCLES(4)) u3 (
        .clk(clk), .rst_n(rst_n), .ena(ena_r[3]), .data_in(data_r[3][4:0]), .valid(valid_r[3]),
        .ready(ready_w[3]), .btn_raw(btn_r[3]), .tx(tx_w[3]), .busy(busy_w[3]),
        .frame_done(done_w[3]), .btn_db(db_w[3]));

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++)
            if (done_w[i] === 1'b1) done_cnt[i]++;
    end

    function automatic int div_of(input int i);
        return (i == 3) ? 3 : 4;
    endfunction
    function automatic int nb_of(input int i);
        return (i == 3) ? 5 : 8;
    endfunction
    function automatic int par_of(input int i);
        return (i == 1) ? 1 : ((i == 2) ? 2 : 0);
    endfunction
    function automatic int sb_of(input int i);
        return (i == 3) ? 2 : 1;
    endfunction

    // Reference: list of serial bits for one frame, one entry per bit period
    function automatic void frame_bits(input int i, input logic [8:0] d,
                                       output logic [15:0] fb, output int nb);
        int   k;
        logic p;
        fb = '0;
        k  = 0;
        p  = 1'b0;
        fb[k] = 1'b0; k++;
        for (int b = 0; b < nb_of(i); b++) begin
            fb[k] = d[b];
            p     = p ^ d[b];
            k++;
        end
        if (par_of(i) == 1) begin fb[k] = p;  k++; end
        if (par_of(i) == 2) begin fb[k] = ~p; k++; end
        for (int s = 0; s < sb_of(i); s++) begin fb[k] = 1'b1; k++; end
        nb = k;
    endfunction

    task automatic check_bit(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check64(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called at the negedge right after the accept edge; samples L+1 cycles
    task automatic capture(input int i, input logic [15:0] fb, input int nb,
                           input int ena_off, input int btn_off, input int btn_on,
                           input string nm);
        int          dv;
        int          len;
        logic [63:0] tw, bw, dw, etw, ebw, edw;
        dv  = div_of(i);
        len = nb * dv;
        tw = '0; bw = '0; dw = '0; etw = '0; ebw = '0; edw = '0;
        for (int t = 0; t <= len; t++) begin
            tw[t]  = tx_w[i];
            bw[t]  = busy_w[i];
            dw[t]  = done_w[i];
            etw[t] = (t < len) ? fb[t / dv] : 1'b1;
            ebw[t] = (t < len);
            edw[t] = (t == len - 1);
            if (t == ena_off) ena_r[i] = 1'b0;
            if (t == btn_off) btn_r[i] = 1'b0;
            if (t == btn_on)  btn_r[i] = 1'b1;
            data_r[i] = 9'($urandom);
            if (t < len) @(negedge clk);
        end
        check64({nm, "_tx"}, tw, etw);
        check64({nm, "_busy"}, bw, ebw);
        check64({nm, "_done"}, dw, edw);
    endtask

    task automatic run_frame(input int i, input logic [8:0] d, input logic [15:0] fb,
                             input int nb, input string nm);
        @(negedge clk);
        data_r[i]  = d;
        valid_r[i] = 1'b1;
        check_bit({nm, "_ready"}, ready_w[i], 1'b1);
        @(negedge clk);
        valid_r[i] = 1'b0;
        capture(i, fb, nb, -1, -1, -1, nm);
    endtask

    typedef struct {
        int          inst;
        logic [8:0]  data;
        int          nb;
        logic [15:0] bits;
    } vec_t;

    vec_t vecs [8];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [15:0] fb;
        int          nb;
        int          n;
        int          d0;
        logic        bad;

        vecs[0] = '{0, 9'h0A5, 10, 16'h034A};
        vecs[1] = '{1, 9'h007, 11, 16'h060E};
        vecs[2] = '{2, 9'h007, 11, 16'h040E};
        vecs[3] = '{3, 9'h01F,  8, 16'h00FE};
        vecs[4] = '{0, 9'h000, 10, 16'h0200};
        vecs[5] = '{0, 9'h0FF, 10, 16'h03FE};
        vecs[6] = '{1, 9'h000, 11, 16'h0400};
        vecs[7] = '{2, 9'h000, 11, 16'h0600};

        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ena_r[i] = 1'b1; valid_r[i] = 1'b0; btn_r[i] = 1'b0; data_r[i] = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check_bit("reset_tx", tx_w[i], 1'b1);
            check_bit("reset_busy", busy_w[i], 1'b0);
            check_bit("reset_done", done_w[i], 1'b0);
            check_bit("reset_btn_db", db_w[i], 1'b0);
        end
        rst_n = 1'b1;

        // Vector table
        for (int v = 0; v < 8; v++)
            run_frame(vecs[v].inst, vecs[v].data, vecs[v].bits, vecs[v].nb, $sformatf("vec%0d", v));

        // Back-to-back with valid held: 24-cycle frames, one idle cycle between
        begin : b2b
            logic [63:0] tw, bw, dw, etw, ebw, edw;
            tw = '0; bw = '0; dw = '0; etw = '0; ebw = '0; edw = '0;
            fb = 16'h00FE;
            @(negedge clk);
            data_r[3] = 9'h01F; valid_r[3] = 1'b1;
            @(negedge clk);
            for (int t = 0; t < 50; t++) begin
                tw[t] = tx_w[3]; bw[t] = busy_w[3]; dw[t] = done_w[3];
                etw[t] = (t < 24) ? fb[t / 3] : ((t == 24 || t == 49) ? 1'b1 : fb[(t - 25) / 3]);
                ebw[t] = (t != 24) && (t != 49);
                edw[t] = (t == 23) || (t == 48);
                if (t == 30) valid_r[3] = 1'b0;
                if (t < 49) @(negedge clk);
            end
            check64("b2b_tx", tw, etw);
            check64("b2b_busy", bw, ebw);
            check64("b2b_done", dw, edw);
        end

        // Button bounce then stable press: one frame, second press while busy dropped
        d0 = done_cnt[0];
        data_r[0] = 9'h03C;
        @(negedge clk);
        bad = 1'b0;
        for (int c = 0; c < 20; c++) begin
            btn_r[0] = ((c / 2) % 2 == 0);
            @(negedge clk);
            if (db_w[0] !== 1'b0) bad = 1'b1;
        end
        check_bit("bounce_db_low", bad, 1'b0);
        btn_r[0] = 1'b1;
        n = 0;
        while (db_w[0] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_int("btn_db_delay", n, 6);
        @(negedge clk);
        frame_bits(0, 9'h03C, fb, nb);
        capture(0, fb, nb, -1, 2, 14, "btn");
        repeat (40) @(negedge clk);
        check_int("btn_frames", done_cnt[0] - d0, 1);
        check_bit("btn_db_second", db_w[0], 1'b1);
        btn_r[0] = 1'b0;
        repeat (12) @(negedge clk);
        check_bit("btn_db_release", db_w[0], 1'b0);
        check_int("btn_frames_after", done_cnt[0] - d0, 1);

        // Reset during DATA bit 3 of 0xA5 (that bit is 0)
        @(negedge clk);
        data_r[0] = 9'h0A5; valid_r[0] = 1'b1;
        @(negedge clk);
        valid_r[0] = 1'b0;
        repeat (17) @(negedge clk);
        check_bit("pre_rst_tx", tx_w[0], 1'b0);
        rst_n = 1'b0;
        #1;
        check_bit("rst_mid_tx", tx_w[0], 1'b1);
        check_bit("rst_mid_busy", busy_w[0], 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_frame(0, 9'h0A5, 16'h034A, 10, "post_rst");

        // ena low holds off the frame; dropping ena mid-frame does not abort it
        @(negedge clk);
        ena_r[0] = 1'b0; valid_r[0] = 1'b1; data_r[0] = 9'h081;
        bad = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (ready_w[0] !== 1'b0 || tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) bad = 1'b1;
        end
        check_bit("ena_off_idle", bad, 1'b0);
        data_r[0] = 9'h081;
        ena_r[0] = 1'b1;
        @(negedge clk);
        valid_r[0] = 1'b0;
        frame_bits(0, 9'h081, fb, nb);
        capture(0, fb, nb, 5, -1, -1, "ena");
        check_bit("ena_off_ready", ready_w[0], 1'b0);
        ena_r[0] = 1'b1;

        // Random frames against the model
        for (int r = 0; r < 24; r++) begin
            int         i;
            logic [8:0] d;
            i = int'($urandom_range(0, 3));
            d = 9'($urandom) & ((9'd1 << nb_of(i)) - 9'd1);
            frame_bits(i, d, fb, nb);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_frame(i, d, fb, nb, $sformatf("rand%0d_u%0d", r, i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
